// File: rtl/vco_freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// vco_freq_meter_pkg
// Shared definitions for the VCO frequency meter:
//   - state_t       : measurement FSM encoding (IDLE=0, MEASURE=1, DONE=2)
//   - CLK_FREQ_HZ   : nominal system clock frequency
//   - count_to_hz() : converts a window count into a frequency in Hz
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package vco_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam longint unsigned CLK_FREQ_HZ = 64'd100_000_000;

    // Measured frequency = count * f_clk / gate length.
    function automatic longint unsigned count_to_hz(
        input longint unsigned cnt,
        input longint unsigned gate_cycles
    );
        return (cnt * CLK_FREQ_HZ) / gate_cycles;
    endfunction

endpackage

// File: rtl/vco_freq_meter_if.sv
// ---------------------------------------------------------------------------
// vco_freq_meter_if
// Control/result bundle of the VCO frequency meter.
//   start    : single-shot measurement request   (master -> slave)
//   cont     : continuous measurement mode       (master -> slave)
//   count    : edge count of last window         (slave -> master)
//   valid    : one-cycle result strobe           (slave -> master)
//   overflow : edge counter saturated in window  (slave -> master)
//   busy     : measurement in progress           (slave -> master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface vco_freq_meter_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic                   cont;
    logic [COUNT_WIDTH-1:0] count;
    logic                   valid;
    logic                   overflow;
    logic                   busy;

    modport master (
        output start,
        output cont,
        input  count,
        input  valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  start,
        input  cont,
        output count,
        output valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/vco_freq_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous input into the clk domain through a SYNC_STAGES
// flop chain and flags its rising edges.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears all flops)
//   din  : asynchronous input
//   rise : one-cycle pulse per synchronized rising edge of din
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;

    // Synchronizer chain plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r   <= '0;
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], din};
            sync_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~sync_d_r;

endmodule

// File: rtl/vco_freq_meter.sv
// ---------------------------------------------------------------------------
// vco_freq_meter
// Counts rising edges of the asynchronous VCO clock over a gate window of
// GATE_CYCLES system clocks and reports the count with a one-cycle strobe.
//   clk : system clock (100 MHz nominal)
//   rst : synchronous active-high reset; aborts any window in progress
//   fin : VCO clock, asynchronous to clk (high/low phases >= 2 clk periods)
//   bus : vco_freq_meter_if.slave -- start/cont in, count/valid/overflow/busy out
// Timing: start sampled at edge N -> busy after N, valid after N+1+GATE_CYCLES.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vco_freq_meter
    import vco_freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fin,
    vco_freq_meter_if.slave    bus
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] EDGE_MAX = '1;

    state_t                 state_r;
    state_t                 state_s;
    logic                   clear_s;
    logic                   rise_s;
    logic [GATE_W-1:0]      gate_r;
    logic [COUNT_WIDTH-1:0] edge_cnt_r;
    logic                   sat_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   valid_r;
    logic                   overflow_r;
    logic                   busy_r;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .din  (fin),
        .rise (rise_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clear_s opens a fresh window (both counters and sat flag).
    always_comb begin
        state_s = state_r;
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_MEASURE;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (gate_r == GATE_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_DONE: begin
                if (bus.cont) begin
                    state_s = ST_MEASURE;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Gate and edge counters; edges seen while not measuring (IDLE/DONE) are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_r     <= '0;
            edge_cnt_r <= '0;
            sat_r      <= 1'b0;
        end else if (clear_s) begin
            gate_r     <= '0;
            edge_cnt_r <= '0;
            sat_r      <= 1'b0;
        end else if (state_r == ST_MEASURE) begin
            gate_r <= gate_r + GATE_W'(1);
            if (rise_s) begin
                // Counter holds at all-ones; further edges only mark saturation.
                if (edge_cnt_r == EDGE_MAX) begin
                    sat_r <= 1'b1;
                end else begin
                    edge_cnt_r <= edge_cnt_r + COUNT_WIDTH'(1);
                end
            end
        end else begin
            gate_r     <= gate_r;
            edge_cnt_r <= edge_cnt_r;
            sat_r      <= sat_r;
        end
    end

    // Registered result outputs: latched in DONE, held until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= '0;
            overflow_r <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            valid_r <= (state_r == ST_DONE);
            busy_r  <= (state_s != ST_IDLE);
            if (state_r == ST_DONE) begin
                count_r    <= edge_cnt_r;
                overflow_r <= sat_r;
            end else begin
                count_r    <= count_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign bus.count    = count_r;
    assign bus.valid    = valid_r;
    assign bus.overflow = overflow_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_vco_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_vco_freq_meter
// Directed bench for vco_freq_meter. fin is derived from clk with an exact
// period of 2*fin_half clk cycles, so a 1000-cycle window holds an exact
// number of edges (1000 / period) independent of phase.
// dut_a: COUNT_WIDTH=16, dut_b: COUNT_WIDTH=4 (saturation behaviour).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vco_freq_meter;
    import vco_freq_meter_pkg::*;

    logic clk;
    logic rst;
    logic fin;
    logic start_req;
    logic cont_a;
    logic sel_b;
    int   fin_half;
    logic fin_level;
    int   fin_cnt;

    int n_vec;
    int n_bad;

    vco_freq_meter_if #(.COUNT_WIDTH(16)) ia ();
    vco_freq_meter_if #(.COUNT_WIDTH(4))  ib ();

    assign ia.start = start_req & ~sel_b;
    assign ib.start = start_req & sel_b;
    assign ia.cont  = cont_a;
    assign ib.cont  = 1'b0;

    logic        mux_valid;
    logic [15:0] mux_count;
    logic        mux_ovf;
    logic        mux_busy;

    assign mux_valid = sel_b ? ib.valid    : ia.valid;
    assign mux_count = sel_b ? 16'(ib.count) : ia.count;
    assign mux_ovf   = sel_b ? ib.overflow : ia.overflow;
    assign mux_busy  = sel_b ? ib.busy     : ia.busy;

    vco_freq_meter #(
        .GATE_CYCLES (1000),
        .COUNT_WIDTH (16),
        .SYNC_STAGES (2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .fin (fin),
        .bus (ia)
    );

    vco_freq_meter #(
        .GATE_CYCLES (1000),
        .COUNT_WIDTH (4),
        .SYNC_STAGES (2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .fin (fin),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fin generator: toggles every fin_half clk cycles, or holds fin_level when fin_half is 0.
    always @(negedge clk) begin
        if (fin_half == 0) begin
            fin = fin_level;
            fin_cnt = 0;
        end else if (fin_cnt >= fin_half - 1) begin
            fin_cnt = 0;
            fin = ~fin;
        end else begin
            fin_cnt = fin_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Pulses start, then waits (bounded) for valid. poke_at re-pulses start k cycles in.
    task automatic run_window(input int poke_at, output int lat, output int cnt,
                              output int ovf, output int bsy, output int bsy0);
        lat = -1; cnt = -1; ovf = -1; bsy = -1;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        bsy0 = int'(mux_busy);
        for (int k = 1; k <= 1200 && lat < 0; k++) begin
            @(negedge clk);
            start_req = (k == poke_at);
            if (mux_valid) begin
                lat = k;
                cnt = int'(mux_count);
                ovf = int'(mux_ovf);
                bsy = int'(mux_busy);
            end
        end
        start_req = 1'b0;
    endtask

    int lat, cnt, ovf, bsy, bsy0, seen, nv;
    int vk[3];
    int vc[3];
    int vb[3];

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; start_req = 1'b0; cont_a = 1'b0; sel_b = 1'b0;
        fin = 1'b0; fin_half = 20; fin_level = 1'b0; fin_cnt = 0;
        vk = '{default: 0}; vc = '{default: 0}; vb = '{default: 0};

        repeat (5) @(negedge clk);
        check_val("rst_count", int'(ia.count), 0);
        check_val("rst_valid", int'(ia.valid), 0);
        check_val("rst_ovf",   int'(ia.overflow), 0);
        check_val("rst_busy",  int'(ia.busy), 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        // 2.5 MHz single shot with a stray start mid-window.
        run_window(500, lat, cnt, ovf, bsy, bsy0);
        check_val("single_busy0", bsy0, 1);
        check_val("single_lat",   lat, 1001);
        check_val("single_cnt",   cnt, 25);
        check_val("single_ovf",   ovf, 0);
        check_val("single_busy_end", bsy, 0);
        check_val("single_hz", int'(count_to_hz(longint'(cnt), 1000)), 2_500_000);
        @(negedge clk);
        check_val("valid_strobe", int'(ia.valid), 0);
        seen = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (ia.valid) seen = seen + 1;
        end
        check_val("stray_start_ignored", seen, 0);

        // Static fin, low then high.
        fin_half = 0; fin_level = 1'b0;
        repeat (20) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("static0_cnt", cnt, 0);
        check_val("static0_ovf", ovf, 0);
        fin_level = 1'b1;
        repeat (20) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("static1_cnt", cnt, 0);
        check_val("static1_ovf", ovf, 0);

        // Continuous mode at 10 MHz: three windows 1001 cycles apart.
        fin_half = 5;
        repeat (300) @(negedge clk);
        cont_a = 1'b1;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        nv = 0;
        for (int k = 1; k <= 3500 && nv < 3; k++) begin
            @(negedge clk);
            if (ia.valid) begin
                vk[nv] = k; vc[nv] = int'(ia.count); vb[nv] = int'(ia.busy);
                nv = nv + 1;
            end
        end
        cont_a = 1'b0;
        check_val("cont_n",    nv, 3);
        check_val("cont_lat0", vk[0], 1001);
        check_val("cont_gap1", vk[1] - vk[0], 1001);
        check_val("cont_gap2", vk[2] - vk[1], 1001);
        check_val("cont_cnt0", vc[0], 100);
        check_val("cont_cnt1", vc[1], 100);
        check_val("cont_cnt2", vc[2], 100);
        check_val("cont_busy", vb[0], 1);

        // Reset 500 cycles into the window that follows.
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_count", int'(ia.count), 0);
        check_val("midrst_valid", int'(ia.valid), 0);
        check_val("midrst_ovf",   int'(ia.overflow), 0);
        check_val("midrst_busy",  int'(ia.busy), 0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (ia.valid) seen = seen + 1;
        end
        check_val("midrst_no_valid", seen, 0);
        fin_half = 50;
        repeat (300) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("after_rst_lat", lat, 1001);
        check_val("after_rst_cnt", cnt, 10);

        // 4-bit counter: saturation and sticky-flag clearing.
        sel_b = 1'b1;
        fin_half = 5;
        repeat (300) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("sat10m_cnt", cnt, 15);
        check_val("sat10m_ovf", ovf, 1);
        fin_half = 20;
        repeat (300) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("sat2m5_cnt", cnt, 15);
        check_val("sat2m5_ovf", ovf, 1);
        fin_half = 50;
        repeat (300) @(negedge clk);
        run_window(0, lat, cnt, ovf, bsy, bsy0);
        check_val("sat1m_cnt", cnt, 10);
        check_val("sat1m_ovf", ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
